// File: rtl/ifetch_align_pkg.sv
// Shared fetch-stage types: halfword/word aliases and the fetch FSM state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rv32i_types;

   typedef logic [31:0] rv32i_word;
   typedef logic [15:0] rv32i_half;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DROP  = 2'd2
   } ifetch_state_t;

endpackage

// File: rtl/ifetch_align_hw_queue.sv
// Three-entry halfword shift queue; pop 0..2 from the head and push 0..2 at the tail in one cycle.
// Latency: pushed halfwords are visible at the head outputs the cycle after the push.
// Backpressure: none internally; the caller never pushes past 3 entries. flush empties the queue.
// Ports: clk/rst, flush, pop_n/push_n (halfword counts), push_lo/push_hi (push order lo then hi),
//        hw0/hw1 (head two slots), count (occupancy), count_next (occupancy after this cycle).
module hw_queue
   import rv32i_types::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic [1:0] pop_n,
   input  logic [1:0] push_n,
   input  rv32i_half  push_lo,
   input  rv32i_half  push_hi,
   output rv32i_half  hw0,
   output rv32i_half  hw1,
   output logic [1:0] count,
   output logic [1:0] count_next
);

   rv32i_half  slot      [3];
   rv32i_half  shifted   [3];
   rv32i_half  slot_next [3];
   logic [1:0] base;

   always_comb begin
      shifted[0] = slot[0];
      shifted[1] = slot[1];
      shifted[2] = slot[2];
      case (pop_n)
         2'd1: begin
            shifted[0] = slot[1];
            shifted[1] = slot[2];
            shifted[2] = '0;
         end
         2'd2: begin
            shifted[0] = slot[2];
            shifted[1] = '0;
            shifted[2] = '0;
         end
         default: ;
      endcase

      // New halfwords land just above whatever survives the pop.
      base = 2'(count - pop_n);
      for (int i = 0; i < 3; i++) begin
         slot_next[i] = shifted[i];
         if (push_n != 2'd0 && 2'(i) == base)
            slot_next[i] = push_lo;
         if (push_n == 2'd2 && 2'(i) == 2'(base + 2'd1))
            slot_next[i] = push_hi;
      end

      count_next = flush ? 2'd0 : 2'(count - pop_n + push_n);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++)
            slot[i] <= '0;
         count <= 2'd0;
      end else begin
         for (int i = 0; i < 3; i++)
            slot[i] <= slot_next[i];
         count <= count_next;
      end
   end

   assign hw0 = slot[0];
   assign hw1 = slot[1];

endmodule

// File: rtl/ifetch_align.sv
// Instruction fetch/realign: word fetches in, one whole (32-bit or zero-extended RVC) instruction out.
// Latency: imem_resp in cycle N gives ir_valid in cycle N+1; a straddling instruction the cycle after its second word.
// Backpressure: stall holds ir/ir_pc; fetching pauses once two or more halfwords are buffered.
// Ports: clk, rst (sync, active-high); imem_read/imem_address/imem_resp/imem_rdata memory port;
//        redirect/redirect_pc restart; stall from decode; ir_valid/ir/ir_pc/ir_compressed to decode.
module ifetch_align
   import rv32i_types::*;
#(
   parameter rv32i_word RESET_PC = 32'h0000_0060
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_read,
   output rv32i_word   imem_address,
   input  logic        imem_resp,
   input  rv32i_word   imem_rdata,
   input  logic        redirect,
   input  rv32i_word   redirect_pc,
   input  logic        stall,
   output logic        ir_valid,
   output rv32i_word   ir,
   output rv32i_word   ir_pc,
   output logic        ir_compressed
);

   ifetch_state_t state;
   rv32i_word     head_pc;
   rv32i_word     fetch_pc;
   rv32i_word     fetch_pc_next;
   logic          drop_low;

   rv32i_half     hw0;
   rv32i_half     hw1;
   logic [1:0]    count;
   logic [1:0]    count_next;
   logic [1:0]    pop_n;
   logic [1:0]    push_n;
   rv32i_half     push_lo;

   logic          head_c;
   logic          head_ready;
   logic          consume;
   logic          append;

   // Halfword PCs never use bit 0 of the redirect target.
   logic          unused_pc_bit;
   assign unused_pc_bit = redirect_pc[0];

   always_comb begin
      head_c     = (hw0[1:0] != 2'b11);
      head_ready = head_c ? (count != 2'd0) : (count >= 2'd2);
      // In DROP the queue was just flushed; gate anyway so nothing stale escapes.
      ir_valid      = head_ready && (state != DROP);
      ir            = '0;
      if (ir_valid)
         ir = head_c ? {16'h0000, hw0} : {hw1, hw0};
      ir_compressed = ir_valid && head_c;
      ir_pc         = head_pc;
      imem_read     = (state != IDLE);

      // A redirect kills both the consume and any arriving data this cycle.
      consume = ir_valid && !stall && !redirect;
      append  = (state == FETCH) && imem_resp && !redirect;
      pop_n   = consume ? (head_c ? 2'd1 : 2'd2) : 2'd0;
      push_n  = append ? (drop_low ? 2'd1 : 2'd2) : 2'd0;
      push_lo = drop_low ? imem_rdata[31:16] : imem_rdata[15:0];

      fetch_pc_next = fetch_pc;
      if (redirect)
         fetch_pc_next = {redirect_pc[31:2], 2'b00};
      else if (append)
         fetch_pc_next = fetch_pc + 32'd4;
   end

   hw_queue u_hw_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .pop_n      (pop_n),
      .push_n     (push_n),
      .push_lo    (push_lo),
      .push_hi    (imem_rdata[31:16]),
      .hw0        (hw0),
      .hw1        (hw1),
      .count      (count),
      .count_next (count_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         head_pc      <= RESET_PC;
         fetch_pc     <= RESET_PC;
         drop_low     <= 1'b0;
         imem_address <= RESET_PC;
      end else begin
         fetch_pc <= fetch_pc_next;
         if (redirect) begin
            head_pc  <= {redirect_pc[31:1], 1'b0};
            drop_low <= redirect_pc[1];
         end else begin
            if (consume)
               head_pc <= head_pc + (head_c ? 32'd2 : 32'd4);
            if (append)
               drop_low <= 1'b0;
         end

         // imem_address only reloads when a new read begins, so it stays
         // fixed across a DROP even though fetch_pc has been retargeted.
         case (state)
            IDLE: begin
               if (redirect || count_next <= 2'd1) begin
                  state        <= FETCH;
                  imem_address <= fetch_pc_next;
               end
            end
            FETCH: begin
               if (redirect && !imem_resp) begin
                  state <= DROP;
               end else if (imem_resp && !redirect && count_next > 2'd1) begin
                  state <= IDLE;
               end else begin
                  state        <= FETCH;
                  imem_address <= fetch_pc_next;
               end
            end
            DROP: begin
               if (imem_resp) begin
                  state        <= FETCH;
                  imem_address <= fetch_pc_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_align.sv
module tb_ifetch_align;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_read;
   logic [31:0] imem_address;
   logic        imem_resp;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        ir_valid;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic        ir_compressed;

   always #5 clk = ~clk;

   ifetch_align #(.RESET_PC(32'h0000_0060)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_read     (imem_read),
      .imem_address  (imem_address),
      .imem_resp     (imem_resp),
      .imem_rdata    (imem_rdata),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .stall         (stall),
      .ir_valid      (ir_valid),
      .ir            (ir),
      .ir_pc         (ir_pc),
      .ir_compressed (ir_compressed)
   );

   typedef struct {
      logic [31:0] ir;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mem [logic [31:0]];
   int          resp_cyc [logic [31:0]];
   int          resp_cnt [logic [31:0]];
   int          first_valid [logic [31:0]];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          resp_lat = 0;
   int          wait_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      if (mem.exists(a))
         return mem[a];
      return {a[17:2], a[15:2], 2'b11};
   endfunction

   function automatic logic [15:0] half(input logic [31:0] a);
      logic [31:0] w;
      w = memword({a[31:2], 2'b00});
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   // Architectural instruction stream from pc: independent of how the DUT buffers.
   task automatic sb_start(input logic [31:0] pc0, input int n);
      logic [31:0] pc;
      logic [15:0] h;
      exp_t        e;
      sb.delete();
      first_valid.delete();
      resp_cyc.delete();
      resp_cnt.delete();
      pc = pc0;
      for (int i = 0; i < n; i++) begin
         h = half(pc);
         e.pc = pc;
         if (h[1:0] != 2'b11) begin
            e.ir = {16'h0000, h};
            pc   = pc + 32'd2;
         end else begin
            e.ir = {half(pc + 32'd2), h};
            pc   = pc + 32'd4;
         end
         sb.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory responder: resp after resp_lat waiting cycles of a held read.
   initial begin
      imem_resp  = 1'b0;
      imem_rdata = '0;
      forever begin
         tick();
         imem_resp = 1'b0;
         if (!rst && imem_read) begin
            if (wait_cnt >= resp_lat) begin
               imem_resp  = 1'b1;
               imem_rdata = memword(imem_address);
               resp_cyc[imem_address] = cyc;
               resp_cnt[imem_address] = resp_cnt.exists(imem_address) ? resp_cnt[imem_address] + 1 : 1;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Scoreboard monitor: compare every consumed instruction.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst) begin
         if (ir_valid && !first_valid.exists(ir_pc))
            first_valid[ir_pc] = cyc;
         if (ir_valid && !stall && !redirect && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_ir", ir, e.ir);
            chk("sb_pc", ir_pc, e.pc);
            chk("sb_compressed", {31'b0, ir_compressed}, {31'b0, (e.ir[1:0] != 2'b11)});
         end
      end
   end

   task automatic do_reset(input logic [31:0] pc0, input int n);
      rst = 1'b1;
      tick();
      tick();
      sb_start(pc0, n);
      rst = 1'b0;
   endtask

   task automatic do_redirect(input logic [31:0] pc_in, input int n);
      redirect    = 1'b1;
      redirect_pc = pc_in;
      sb_start({pc_in[31:1], 1'b0}, n);
      tick();
      redirect    = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   function automatic logic [31:0] gap(input logic [31:0] vpc, input logic [31:0] rpc);
      if (first_valid.exists(vpc) && resp_cyc.exists(rpc))
         return 32'(first_valid[vpc] - resp_cyc[rpc]);
      return 32'hffff_ffff;
   endfunction

   initial begin
      int  n;
      logic found;
      redirect    = 1'b0;
      redirect_pc = '0;
      stall       = 1'b0;

      // Reset values and first fetch
      mem[32'h60] = 32'h0050_0093;
      tick();
      tick();
      chk("rst_imem_read", {31'b0, imem_read}, 32'd0);
      chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
      chk("rst_ir", ir, 32'd0);
      chk("rst_ir_pc", ir_pc, 32'h60);
      chk("rst_ir_compressed", {31'b0, ir_compressed}, 32'd0);
      do_reset(32'h60, 3);
      n = 0;
      while (!imem_read && n < 20) begin
         tick();
         n++;
      end
      tick();
      n = 0;
      chk("first_read_addr", imem_address, 32'h60);
      drain("drain_reset_fetch");
      chk("resp_to_valid", gap(32'h60, 32'h60), 32'd1);

      // Two compressed instructions in one word, fetched once
      mem[32'h60] = 32'h4585_4505;
      do_reset(32'h60, 4);
      drain("drain_two_rvc");
      chk("one_fetch_0x60", resp_cnt.exists(32'h60) ? 32'(resp_cnt[32'h60]) : 32'd0, 32'd1);

      // Straddling 32-bit instruction
      mem[32'h60] = 32'h0093_4505;
      mem[32'h64] = 32'h1234_0050;
      do_reset(32'h60, 5);
      drain("drain_straddle");
      chk("straddle_latency", gap(32'h62, 32'h64), 32'd1);

      // Halfword redirect target, bit 0 ignored
      mem[32'h80] = 32'h0001_4505;
      do_redirect(32'h83, 4);
      drain("drain_half_redirect");
      chk("half_redirect_fetch", resp_cnt.exists(32'h80) ? 32'(resp_cnt[32'h80]) : 32'd0, 32'd1);

      // Redirect while a read is outstanding
      mem[32'h60] = 32'h0050_0093;
      resp_lat = 3;
      do_reset(32'h60, 1);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (imem_read && imem_address == 32'h64)
            found = 1'b1;
      end
      chk("saw_read_0x64", {31'b0, found}, 32'd1);
      do_redirect(32'h100, 4);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         chk("drop_addr_held", imem_address, 32'h64);
         chk("drop_read_held", {31'b0, imem_read}, 32'd1);
         chk("drop_no_valid", {31'b0, ir_valid}, 32'd0);
         if (imem_resp)
            found = 1'b1;
         tick();
      end
      chk("drop_resp_seen", {31'b0, found}, 32'd1);
      chk("after_drop_read", {31'b0, imem_read}, 32'd1);
      chk("after_drop_addr", imem_address, 32'h100);
      resp_lat = 0;
      drain("drain_after_drop");

      // Stall holds the head and lets fetch go idle
      mem[32'h200] = 32'h4509_4505;
      mem[32'h204] = 32'h460d_4589;
      do_redirect(32'h200, 6);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (ir_valid) begin
            found = 1'b1;
            stall = 1'b1;
         end else begin
            tick();
         end
      end
      chk("stall_valid_seen", {31'b0, found}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ir", ir, sb.size() > 0 ? sb[0].ir : 32'hdead_beef);
         chk("stall_ir_pc", ir_pc, sb.size() > 0 ? sb[0].pc : 32'hdead_beef);
         if (i == 4) begin
            chk("stall_fetch_idle", {31'b0, imem_read}, 32'd0);
            chk("stall_still_valid", {31'b0, ir_valid}, 32'd1);
         end
         tick();
      end
      stall = 1'b0;
      drain("drain_after_stall");

      // Redirect coinciding with resp and consume
      mem[32'h300] = 32'h4591_4511;
      do_redirect(32'h200, 8);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (imem_read && ir_valid)
            found = 1'b1;
         else
            tick();
      end
      chk("collide_cycle_seen", {31'b0, found}, 32'd1);
      do_redirect(32'h300, 4);
      chk("collide_read", {31'b0, imem_read}, 32'd1);
      chk("collide_addr", imem_address, 32'h300);
      chk("collide_flushed", {31'b0, ir_valid}, 32'd0);
      drain("drain_collide");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
